shift_reg_universal_sync: RTL and testbench
===========================================

# shift_reg_universal_sync

Parametrised universal shift register with synchronous reset: the successor to the single-bit D flip-flop. It stores a WIDTH-bit word and supports hold, parallel load, clear, logical shift left/right, rotate left/right, and an automatic burst mode. Burst mode serialises the whole word out LSB-first over WIDTH clocks and reports completion. It sits in the sequential-circuits library as the storage and serial-transfer element for later serial-transfer and serial-adder examples.

## Interface
- WIDTH, 8, word width; legal range 2..32.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into qd by reset_sync.
- clk  input  1  clock; all state updates on its rising edge.
- reset_sync  input  1  reset, synchronous and active-high; highest priority.
- enable  input  1  high: the command on mode executes this edge (IDLE), or the burst advances (BUSY).
- mode  input  3  command: 0 hold, 1 load, 2 shift right, 3 shift left, 4 rotate right, 5 rotate left, 6 burst right, 7 clear.
- data  input  WIDTH  parallel load word.
- serial_in_r  input  1  bit entering the MSB on right shifts (modes 2, 6).
- serial_in_l  input  1  bit entering the LSB on left shifts (mode 3).
- qd  output  WIDTH  register contents.
- serial_out_r  output  1  qd[0], combinational from the register.
- serial_out_l  output  1  qd[WIDTH-1], combinational from the register.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last burst shift.

## Operation
- State machine has two states, IDLE and BUSY. There is an internal down-counter cnt of $clog2(WIDTH) bits.
- Reset (reset_sync=1 at an edge) sets:
  - qd=RESET_VALUE, busy=0, done=0, cnt=0, state=IDLE.
  - Reset overrides enable, mode and a burst in progress.
- IDLE with enable=0: qd holds.
- IDLE with enable=1, by mode:
  - 0: qd holds.
  - 1: qd<=data.
  - 2: qd<={serial_in_r, qd[WIDTH-1:1]}.
  - 3: qd<={qd[WIDTH-2:0], serial_in_l}.
  - 4: qd<={qd[0], qd[WIDTH-1:1]}.
  - 5: qd<={qd[WIDTH-2:0], qd[WIDTH-1]}.
  - 7: qd<=0 (not RESET_VALUE).
  - 6 (accept edge): performs the first right shift (same as mode 2), cnt<=WIDTH-1, state<=BUSY, busy<=1.
- BUSY with enable=1: right-shift using serial_in_r, cnt<=cnt-1. When cnt==1 at the edge, this is the last shift: state<=IDLE, busy<=0, done<=1.
- BUSY with enable=0: qd and cnt freeze. The burst pauses and is not aborted.
- BUSY ignores mode and data entirely.
- done is high for exactly one cycle, then clears. A new command issued in IDLE while done=1 is accepted normally.

## Timing
- Every command has one-edge latency: qd reflects the command immediately after the edge where enable=1.
- Burst with enable held high:
  - Exactly WIDTH shifts: one on the accept edge plus WIDTH-1 in BUSY.
  - busy is high for WIDTH-1 cycles.
  - done rises on the edge where busy falls.
- serial_out_r before the accept edge is bit 0 of the word. After the k-th shift it is original bit k. Bits appear LSB-first, one per enabled edge.
- Each enable=0 cycle during BUSY extends busy by one cycle.
- Reset mid-burst: busy=0 and done=0 after that edge. No done pulse is produced for the aborted burst.
- The outputs have no combinational path from the inputs.

## Test plan (WIDTH=8, RESET_VALUE=0)
- Reset priority: reset_sync=1 for 2 edges with enable=1, mode=1, data=8'hA5 -> qd=8'h00, busy=0, done=0.
- Load and rotate:
  - Load 8'hA5 -> qd=8'hA5.
  - Then mode 4 -> qd=8'hD2.
  - Then mode 5 -> qd=8'hA5.
  - Then enable=0 for 3 edges -> qd stays 8'hA5.
- Shifts and clear:
  - From 8'h00, mode 2 with serial_in_r=1 for 3 edges -> qd=8'hE0.
  - Then mode 3 with serial_in_l=0 -> qd=8'hC0.
  - Then mode 7 -> qd=8'h00.
- Burst:
  - Load 8'hA5, then mode 6 with serial_in_r=0 and enable held high.
  - serial_out_r over successive cycles -> 1,0,1,0,0,1,0,1.
  - After 8 shifts qd=8'h00, busy high for 7 cycles, done high for 1 cycle.
- Burst pause and ignored commands:
  - During a burst from 8'hA5, drop enable for 2 cycles -> qd and shift count frozen; busy lasts 9 cycles.
  - During the same burst, drive mode=1 with data=8'hFF -> ignored.
- Reset mid-burst:
  - Assert reset_sync after the 4th shift -> next edge qd=8'h00, busy=0, and no done pulse.
  - On the following edge, mode=1 with data=8'h3C is accepted -> qd=8'h3C.

Source files
------------

// File: rtl/shift_reg_universal_sync.sv
// -----------------------------------------------------------------------------
// shift_reg_universal_sync
//
// Purpose:
//   WIDTH-bit universal shift register. It supports hold, parallel load, clear,
//   logical shift right/left and rotate right/left. It also has a burst mode
//   that shifts the whole word out LSB-first over WIDTH enabled clocks and
//   then pulses done for one cycle.
//
// Ports:
//   clk           in   rising-edge clock for all state
//   reset_sync    in   synchronous active-high reset, highest priority
//   enable        in   executes the command on mode (IDLE) or advances the
//                      burst (BUSY)
//   mode[2:0]     in   0 hold, 1 load, 2 shr, 3 shl, 4 ror, 5 rol,
//                      6 burst right, 7 clear
//   data[W-1:0]   in   parallel load word
//   serial_in_r   in   bit entering the MSB on right shifts (modes 2 and 6)
//   serial_in_l   in   bit entering the LSB on left shifts (mode 3)
//   qd[W-1:0]     out  register contents
//   serial_out_r  out  qd[0]
//   serial_out_l  out  qd[WIDTH-1]
//   busy          out  burst in progress
//   done          out  one-cycle pulse after the last burst shift
// -----------------------------------------------------------------------------
module shift_reg_universal_sync #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  output logic [WIDTH-1:0] qd,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_SHL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_BURST = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("shift_reg_universal_sync: WIDTH must be in 2..32");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   qd_nxt;
  logic               done_nxt;

  // Shift and rotate helpers.
  function automatic logic [WIDTH-1:0] shr_fn(input logic [WIDTH-1:0] q,
                                              input logic             msb_in);
    return {msb_in, q[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shl_fn(input logic [WIDTH-1:0] q,
                                              input logic             lsb_in);
    return {q[WIDTH-2:0], lsb_in};
  endfunction

  function automatic logic [WIDTH-1:0] ror_fn(input logic [WIDTH-1:0] q);
    return {q[0], q[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rol_fn(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], q[WIDTH-1]};
  endfunction

  // State register: the only sequential process. Reset overrides everything,
  // including a burst in progress.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state <= IDLE;
      cnt   <= '0;
      qd    <= RESET_VALUE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      qd    <= qd_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic. done_nxt defaults to 0, so done is high for one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    qd_nxt    = qd;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          unique case (mode)
            MODE_HOLD:  qd_nxt = qd;
            MODE_LOAD:  qd_nxt = data;
            MODE_SHR:   qd_nxt = shr_fn(qd, serial_in_r);
            MODE_SHL:   qd_nxt = shl_fn(qd, serial_in_l);
            MODE_ROR:   qd_nxt = ror_fn(qd);
            MODE_ROL:   qd_nxt = rol_fn(qd);
            MODE_BURST: begin
              // The accept edge already performs the first of WIDTH shifts.
              qd_nxt    = shr_fn(qd, serial_in_r);
              cnt_nxt   = CNT_W'(WIDTH - 1);
              state_nxt = BUSY;
            end
            MODE_CLEAR: qd_nxt = '0;
            default:    qd_nxt = qd;
          endcase
        end
      end

      BUSY: begin
        // mode and data are ignored here. When enable is low the burst pauses
        // and is not aborted.
        if (enable) begin
          qd_nxt  = shr_fn(qd, serial_in_r);
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: every output is decoded from registers only.
  always_comb begin
    busy         = (state == BUSY);
    serial_out_r = qd[0];
    serial_out_l = qd[WIDTH-1];
  end

endmodule

// File: tb/tb_shift_reg_universal_sync.sv
module tb_shift_reg_universal_sync;

  localparam int W = 8;

  logic         clk_tb = 1'b0;
  logic         reset_sync;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] data;
  logic         serial_in_r;
  logic         serial_in_l;
  logic [W-1:0] qd;
  logic         serial_out_r;
  logic         serial_out_l;
  logic         busy;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         b;
    logic         d;
  } exp_t;

  exp_t sb_q[$];

  shift_reg_universal_sync #(
    .WIDTH      (W),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk         (clk_tb),
    .reset_sync  (reset_sync),
    .enable      (enable),
    .mode        (mode),
    .data        (data),
    .serial_in_r (serial_in_r),
    .serial_in_l (serial_in_l),
    .qd          (qd),
    .serial_out_r(serial_out_r),
    .serial_out_l(serial_out_l),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_tb = ~clk_tb;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, push the expected post-edge state, wait for
  // the edge, then pop and compare.
  task automatic step(input bit r, input bit en, input logic [2:0] m,
                      input logic [W-1:0] d, input bit sir, input bit sil,
                      input logic [W-1:0] eq, input bit eb, input bit ed,
                      input string tag);
    exp_t e;
    @(negedge clk_tb);
    reset_sync  = r;
    enable      = en;
    mode        = m;
    data        = d;
    serial_in_r = sir;
    serial_in_l = sil;
    sb_q.push_back('{tag, eq, eb, ed});
    @(posedge clk_tb);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".qd"},   32'(qd),           32'(e.q));
    chk({e.tag, ".busy"}, 32'(busy),         32'(e.b));
    chk({e.tag, ".done"}, 32'(done),         32'(e.d));
    chk({e.tag, ".sor"},  32'(serial_out_r), 32'(e.q[0]));
    chk({e.tag, ".sol"},  32'(serial_out_l), 32'(e.q[W-1]));
  endtask

  initial begin
    logic [W-1:0] word;
    reset_sync = 1'b1; enable = 1'b0; mode = 3'd0; data = '0;
    serial_in_r = 1'b0; serial_in_l = 1'b0;

    // Reset priority over a load command.
    step(1, 1, 3'd1, 8'hA5, 0, 0, 8'h00, 0, 0, "rst0");
    step(1, 1, 3'd1, 8'hA5, 0, 0, 8'h00, 0, 0, "rst1");

    // Load and rotate.
    step(0, 1, 3'd1, 8'hA5, 0, 0, 8'hA5, 0, 0, "load");
    step(0, 1, 3'd4, 8'h00, 0, 0, 8'hD2, 0, 0, "ror");
    step(0, 1, 3'd5, 8'h00, 0, 0, 8'hA5, 0, 0, "rol");
    for (int i = 0; i < 3; i++)
      step(0, 0, 3'd1, 8'hFF, 1, 1, 8'hA5, 0, 0, "hold_en0");
    step(0, 1, 3'd0, 8'hFF, 1, 1, 8'hA5, 0, 0, "hold_mode0");

    // Shifts and clear.
    step(0, 1, 3'd7, 8'hFF, 0, 0, 8'h00, 0, 0, "clr0");
    step(0, 1, 3'd2, 8'h00, 1, 0, 8'h80, 0, 0, "shr1");
    step(0, 1, 3'd2, 8'h00, 1, 0, 8'hC0, 0, 0, "shr2");
    step(0, 1, 3'd2, 8'h00, 1, 0, 8'hE0, 0, 0, "shr3");
    step(0, 1, 3'd3, 8'h00, 0, 0, 8'hC0, 0, 0, "shl0");
    step(0, 1, 3'd3, 8'h00, 1, 1, 8'h81, 0, 0, "shl1");
    step(0, 1, 3'd7, 8'h00, 0, 0, 8'h00, 0, 0, "clr1");

    // Burst with enable held high; serial_out_r after shift k is bit k of A5.
    step(0, 1, 3'd1, 8'hA5, 0, 0, 8'hA5, 0, 0, "b_load");
    for (int k = 1; k <= W; k++) begin
      word = 8'hA5 >> k;
      step(0, 1, (k == 1) ? 3'd6 : 3'd0, 8'h00, 0, 0, word,
           (k < W), (k == W), $sformatf("burst_k%0d", k));
    end
    step(0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0, "b_done_clr");

    // Burst with a two-cycle pause and ignored load commands.
    step(0, 1, 3'd1, 8'hA5, 0, 0, 8'hA5, 0, 0, "p_load");
    step(0, 1, 3'd6, 8'h00, 0, 0, 8'h52, 1, 0, "p_k1");
    step(0, 1, 3'd1, 8'hFF, 0, 0, 8'h29, 1, 0, "p_k2");
    step(0, 1, 3'd1, 8'hFF, 0, 0, 8'h14, 1, 0, "p_k3");
    step(0, 0, 3'd1, 8'hFF, 1, 1, 8'h14, 1, 0, "p_pause1");
    step(0, 0, 3'd7, 8'hFF, 1, 1, 8'h14, 1, 0, "p_pause2");
    for (int k = 4; k <= W; k++) begin
      word = 8'hA5 >> k;
      step(0, 1, 3'd1, 8'hFF, 0, 0, word, (k < W), (k == W),
           $sformatf("p_k%0d", k));
    end
    // A command issued while done is high is accepted.
    step(0, 1, 3'd1, 8'h5A, 0, 0, 8'h5A, 0, 0, "after_done_load");

    // Reset in the middle of a burst: no done pulse follows.
    step(0, 1, 3'd1, 8'hA5, 0, 0, 8'hA5, 0, 0, "r_load");
    step(0, 1, 3'd6, 8'h00, 0, 0, 8'h52, 1, 0, "r_k1");
    step(0, 1, 3'd0, 8'h00, 0, 0, 8'h29, 1, 0, "r_k2");
    step(0, 1, 3'd0, 8'h00, 0, 0, 8'h14, 1, 0, "r_k3");
    step(0, 1, 3'd0, 8'h00, 0, 0, 8'h0A, 1, 0, "r_k4");
    step(1, 1, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0, "r_reset");
    step(0, 1, 3'd1, 8'h3C, 0, 0, 8'h3C, 0, 0, "r_load3c");
    for (int i = 0; i < 4; i++)
      step(0, 1, 3'd0, 8'h00, 0, 0, 8'h3C, 0, 0, "r_no_done");

    tests_run++;
    assert (sb_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL sb_empty observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
